// File: rtl/data_mem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: FSM encoding, bus width, defaults.
// Pure declarations, no timing or backpressure of its own.
package data_mem_arbiter_pkg;

  localparam int DATA_W               = 16;
  localparam int LEN_W_DEFAULT        = 8;
  localparam int STARVE_LIMIT_DEFAULT = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              re;
    logic              we;
  } mem_req_t;

  function automatic mem_req_t mem_req_idle();
    mem_req_idle = '0;
  endfunction

endpackage

// File: rtl/arb_sat_counter.sv
// Saturating wait counter with synchronous clear; sat_o is a decode of the register.
// One-cycle update latency, no backpressure (clear has priority over increment).
module arb_sat_counter #(
  parameter int LIMIT = 16,
  parameter int CW    = $clog2(LIMIT + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic inc_i,
  input  logic clr_i,
  output logic sat_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != CW'(LIMIT))) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign sat_o = (cnt_q == CW'(LIMIT));

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares one data-memory port: the pipeline always wins, a burst engine takes idle cycles.
// Burst grants start the cycle after sec_start; each pipeline access delays the burst one cycle.
module data_mem_arbiter
  import data_mem_arbiter_pkg::*;
#(
  parameter int LEN_W        = LEN_W_DEFAULT,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_mr,
  input  logic              cpu_mw,
  input  logic [DATA_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              sec_start,
  input  logic              sec_write,
  input  logic [DATA_W-1:0] sec_base,
  input  logic [LEN_W-1:0]  sec_len,
  input  logic [DATA_W-1:0] sec_wdata,
  output logic              sec_wready,
  output logic [DATA_W-1:0] sec_rdata,
  output logic              sec_rvalid,
  output logic              sec_busy,
  output logic              sec_done,
  output logic              sec_starve,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_re,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_e        state_q, state_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  beats_q, beats_d;
  logic              dir_q, dir_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;

  logic     cpu_act;
  logic     grant;
  logic     wait_cyc;
  mem_req_t req;

  assign cpu_act  = cpu_mr | cpu_mw;
  assign grant    = (state_q == ST_RUN) & ~cpu_act;
  assign wait_cyc = (state_q == ST_RUN) & cpu_act;

  always_comb begin
    req = mem_req_idle();
    if (cpu_act) begin
      req.addr  = cpu_addr;
      req.wdata = cpu_wdata;
      req.re    = cpu_mr;
      req.we    = cpu_mw;
    end else if (grant) begin
      req.addr  = addr_q;
      req.wdata = sec_wdata;
      req.re    = ~dir_q;
      req.we    = dir_q;
    end
  end

  assign mem_addr  = req.addr;
  assign mem_wdata = req.wdata;
  assign mem_re    = req.re;
  assign mem_we    = req.we;
  assign cpu_rdata = mem_rdata;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    beats_d  = beats_q;
    dir_d    = dir_q;
    rvalid_d = grant & ~dir_q;
    rdata_d  = rdata_q;
    if (grant && !dir_q) begin
      rdata_d = mem_rdata;
    end
    case (state_q)
      ST_IDLE: begin
        // A zero-length request still reports completion, but never touches memory.
        if (sec_start) begin
          if (sec_len != '0) begin
            addr_d  = sec_base;
            beats_d = sec_len;
            dir_d   = sec_write;
            state_d = ST_RUN;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_RUN: begin
        if (grant) begin
          addr_d  = addr_q + DATA_W'(1);
          beats_d = beats_q - LEN_W'(1);
          if (beats_q == LEN_W'(1)) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      beats_q  <= '0;
      dir_q    <= 1'b0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      beats_q  <= beats_d;
      dir_q    <= dir_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  // Counts consecutive pipeline-stolen cycles while a burst is pending.
  arb_sat_counter #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk   (clk),
    .reset (reset),
    .inc_i (wait_cyc),
    .clr_i (~wait_cyc),
    .sat_o (sec_starve)
  );

  assign sec_wready = grant & dir_q;
  assign sec_rdata  = rdata_q;
  assign sec_rvalid = rvalid_q;
  assign sec_busy   = (state_q == ST_RUN);
  assign sec_done   = (state_q == ST_DONE);

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: burst schedules derived from the idle-cycle list of the pipeline.
module tb_data_mem_arbiter;

  localparam int LEN_W = 8;
  localparam int LIMIT = 16;
  localparam int MAXC  = 128;
  localparam int QUIET = 90;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_mr, cpu_mw;
  logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        sec_start, sec_write;
  logic [15:0] sec_base;
  logic [LEN_W-1:0] sec_len;
  logic [15:0] sec_wdata, sec_rdata;
  logic        sec_wready, sec_rvalid, sec_busy, sec_done, sec_starve;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_re, mem_we;

  always #5 clk = ~clk;

  data_mem_arbiter #(.LEN_W(LEN_W), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .cpu_mr(cpu_mr), .cpu_mw(cpu_mw), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata),
    .sec_start(sec_start), .sec_write(sec_write), .sec_base(sec_base), .sec_len(sec_len),
    .sec_wdata(sec_wdata), .sec_wready(sec_wready), .sec_rdata(sec_rdata),
    .sec_rvalid(sec_rvalid), .sec_busy(sec_busy), .sec_done(sec_done),
    .sec_starve(sec_starve),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_re(mem_re), .mem_we(mem_we),
    .mem_rdata(mem_rdata)
  );

  logic [15:0] mem     [65536];
  logic [15:0] ref_mem [65536];
  logic        load_en;

  always @(posedge clk) begin
    if (load_en) begin
      for (int i = 0; i < 65536; i++) mem[i] <= ref_mem[i];
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end
  assign mem_rdata = mem[mem_addr];

  logic        mr_pat [MAXC];
  logic        mw_pat [MAXC];
  logic [15:0] ca_pat [MAXC];
  logic [15:0] cw_pat [MAXC];
  logic [15:0] wd_arr [256];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_cpu();
    for (int k = 0; k < MAXC; k++) begin
      mr_pat[k] = 1'b0;
      mw_pat[k] = 1'b0;
      ca_pat[k] = 16'($urandom);
      cw_pat[k] = 16'($urandom);
    end
  endtask

  task automatic rand_cpu(input int pct);
    clear_cpu();
    for (int k = 0; k < QUIET; k++) begin
      if ($urandom_range(0, 99) < pct) begin
        if ($urandom_range(0, 1) == 1) mr_pat[k] = 1'b1;
        else                           mw_pat[k] = 1'b1;
      end
    end
  endtask

  task automatic rand_wdata();
    for (int i = 0; i < 256; i++) wd_arr[i] = 16'($urandom);
  endtask

  // Grants are the first len idle pipeline cycles after the start cycle;
  // everything else (done, busy, rvalid, starvation) follows from that list.
  task automatic do_burst(input logic dir, input logic [15:0] base, input int len, input bit restart);
    int          g[$];
    int          run_end, bi, waits;
    logic        gr, exp_rv, nxt_rv, ere, ewe;
    logic [15:0] exp_rd, nxt_rd, ea, ewd, baddr;
    for (int j = 1; j < MAXC - 4 && g.size() < len; j++)
      if (!(mr_pat[j] | mw_pat[j])) g.push_back(j);
    run_end = (len == 0) ? 0 : g[len-1];
    exp_rv  = 1'b0;
    exp_rd  = 16'h0;
    for (int kk = 0; kk <= run_end + 3; kk++) begin
      @(negedge clk);
      bi = 0;
      foreach (g[i]) if (g[i] < kk) bi++;
      gr = 1'b0;
      if (bi < len) gr = (g[bi] == kk);
      baddr = 16'(int'(base) + bi);
      cpu_mr    = mr_pat[kk];
      cpu_mw    = mw_pat[kk];
      cpu_addr  = ca_pat[kk];
      cpu_wdata = cw_pat[kk];
      if (kk == 0) begin
        sec_start = 1'b1; sec_write = dir; sec_base = base; sec_len = LEN_W'(len);
      end else if (restart && kk == 2 && kk <= run_end) begin
        sec_start = 1'b1; sec_write = ~dir; sec_base = 16'($urandom);
        sec_len = LEN_W'($urandom_range(1, 255));
      end else begin
        sec_start = 1'b0; sec_write = 1'($urandom); sec_base = 16'($urandom);
        sec_len = LEN_W'($urandom);
      end
      sec_wdata = (bi < len) ? wd_arr[bi] : 16'($urandom);
      #1;
      ea = 16'h0; ewd = 16'h0; ere = 1'b0; ewe = 1'b0;
      if (cpu_mr | cpu_mw) begin
        ea = cpu_addr; ewd = cpu_wdata; ere = cpu_mr; ewe = cpu_mw;
      end else if (gr) begin
        ea = baddr; ewd = wd_arr[bi]; ere = ~dir; ewe = dir;
      end
      waits = 0;
      for (int j = kk - 1; j >= 1 && j <= run_end && (mr_pat[j] | mw_pat[j]); j--) waits++;
      chk("mem_addr",   32'(mem_addr),   32'(ea));
      chk("mem_wdata",  32'(mem_wdata),  32'(ewd));
      chk("mem_re",     32'(mem_re),     32'(ere));
      chk("mem_we",     32'(mem_we),     32'(ewe));
      chk("sec_wready", 32'(sec_wready), 32'(gr & dir));
      chk("sec_busy",   32'(sec_busy),   32'(len != 0 && kk >= 1 && kk <= run_end));
      chk("sec_done",   32'(sec_done),   32'(kk == run_end + 1));
      chk("sec_starve", 32'(sec_starve), 32'(waits >= LIMIT));
      chk("sec_rvalid", 32'(sec_rvalid), 32'(exp_rv));
      if (exp_rv) chk("sec_rdata", 32'(sec_rdata), 32'(exp_rd));
      if (cpu_mr) chk("cpu_rdata", 32'(cpu_rdata), 32'(ref_mem[cpu_addr]));
      nxt_rv = gr & ~dir;
      nxt_rd = ref_mem[baddr];
      if (cpu_mw)         ref_mem[cpu_addr] = cpu_wdata;
      else if (gr && dir) ref_mem[baddr]    = wd_arr[bi];
      exp_rv = nxt_rv;
      if (nxt_rv) exp_rd = nxt_rd;
    end
    if (dir) begin
      for (int i = 0; i < len; i++)
        chk("mem_after_write", 32'(mem[16'(int'(base) + i)]), 32'(ref_mem[16'(int'(base) + i)]));
    end
  endtask

  initial begin
    reset = 1'b1; load_en = 1'b0;
    cpu_mr = 1'b0; cpu_mw = 1'b0; cpu_addr = 16'h0; cpu_wdata = 16'h0;
    sec_start = 1'b0; sec_write = 1'b0; sec_base = 16'h0; sec_len = '0; sec_wdata = 16'h0;
    for (int i = 0; i < 65536; i++) ref_mem[i] = 16'($urandom);
    ref_mem[0]     = 16'h0000;
    ref_mem[16'h10] = 16'h00A1;
    ref_mem[16'h11] = 16'h00A2;
    ref_mem[16'h12] = 16'h00A3;
    ref_mem[16'h13] = 16'h00A4;
    load_en = 1'b1;
    @(posedge clk);
    #1 load_en = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_mem_addr",   32'(mem_addr),   32'h0);
    chk("rst_mem_wdata",  32'(mem_wdata),  32'h0);
    chk("rst_mem_re",     32'(mem_re),     32'h0);
    chk("rst_mem_we",     32'(mem_we),     32'h0);
    chk("rst_cpu_rdata",  32'(cpu_rdata),  32'h0);
    chk("rst_sec_rdata",  32'(sec_rdata),  32'h0);
    chk("rst_sec_rvalid", 32'(sec_rvalid), 32'h0);
    chk("rst_sec_wready", 32'(sec_wready), 32'h0);
    chk("rst_sec_busy",   32'(sec_busy),   32'h0);
    chk("rst_sec_done",   32'(sec_done),   32'h0);
    chk("rst_sec_starve", 32'(sec_starve), 32'h0);
    reset = 1'b0;

    // Read burst of four preloaded words with the pipeline idle.
    clear_cpu(); rand_wdata();
    do_burst(1'b0, 16'h0010, 4, 1'b0);

    // Write burst with one pipeline write stealing the second grant slot.
    clear_cpu(); rand_wdata();
    mw_pat[2] = 1'b1; ca_pat[2] = 16'h0100; cw_pat[2] = 16'hBEEF;
    do_burst(1'b1, 16'h0020, 3, 1'b0);
    chk("cpu_write_landed", 32'(mem[16'h0100]), 32'h0000BEEF);

    // Address counter wrap, both directions.
    clear_cpu(); rand_wdata();
    do_burst(1'b0, 16'hFFFE, 3, 1'b0);
    clear_cpu(); rand_wdata();
    do_burst(1'b1, 16'hFFFE, 3, 1'b0);

    // Twenty cycles of pipeline reads starve a single-beat burst.
    clear_cpu(); rand_wdata();
    for (int k = 1; k <= 20; k++) mr_pat[k] = 1'b1;
    do_burst(1'b0, 16'h0200, 1, 1'b0);

    // Zero-length request, then a restart attempt while busy.
    clear_cpu(); rand_wdata();
    do_burst(1'b0, 16'h0300, 0, 1'b0);
    clear_cpu(); rand_wdata();
    do_burst(1'b1, 16'h0400, 5, 1'b1);

    // Reset in the middle of a read burst.
    clear_cpu();
    @(negedge clk);
    cpu_mr = 1'b0; cpu_mw = 1'b0;
    sec_start = 1'b1; sec_write = 1'b0; sec_base = 16'h0040; sec_len = LEN_W'(8);
    @(negedge clk);
    sec_start = 1'b0;
    #1;
    chk("mid_busy_before", 32'(sec_busy), 32'h1);
    chk("mid_re_before",   32'(mem_re),   32'h1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid_busy_rst",   32'(sec_busy),   32'h0);
    chk("mid_re_rst",     32'(mem_re),     32'h0);
    chk("mid_rvalid_rst", 32'(sec_rvalid), 32'h0);
    chk("mid_done_rst",   32'(sec_done),   32'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("post_rst_done", 32'(sec_done), 32'h0);
      chk("post_rst_busy", 32'(sec_busy), 32'h0);
    end

    // Randomized bursts against random pipeline traffic.
    for (int n = 0; n < 24; n++) begin
      logic [15:0] b;
      b = ($urandom_range(0, 3) == 0) ? 16'(16'hFFF8 + $urandom_range(0, 7)) : 16'($urandom);
      rand_cpu(30); rand_wdata();
      do_burst(1'($urandom), b, $urandom_range(0, 12), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
